// File: rtl/spin_ctrl.sv
// Spinner motion controller: steps a 0..5 position with a slowing step period, then stops.
// Optional SPINNER_RANDOM_EN adds an LFSR offset to the position on spin entry.
module spin_ctrl #(
  parameter int TICK_DIV     = 1000,
  parameter int START_PERIOD = 2,
  parameter int STOP_PERIOD  = 40,
  parameter int PERIOD_INC   = 1
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  input  logic       start_i,
  output logic [2:0] pos_o,
  output logic       running_o,
  output logic       done_o
);

  typedef enum logic {IDLE, SPIN} state_t;

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);
  localparam logic [7:0]  START_P   = 8'(START_PERIOD);
  localparam logic [8:0]  STOP_P    = 9'(STOP_PERIOD);
  localparam logic [8:0]  INC_P     = 9'(PERIOD_INC);

  state_t      state;
  logic        sync_p0, sync_p1, sync_p2;
  logic        press;
  logic [15:0] prescaler;
  logic [7:0]  step_cnt;
  logic [7:0]  period;
  logic        tick;
  logic [8:0]  next_period;
  logic [2:0]  next_pos;
  logic [2:0]  entry_pos;

  function automatic logic [2:0] mod6(input logic [3:0] v);
    logic [3:0] r;
    r = v;
    if (r >= 4'd12)     r = r - 4'd12;
    else if (r >= 4'd6) r = r - 4'd6;
    return r[2:0];
  endfunction

  // Start synchronizer and rising-edge detector
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= start_i;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign press       = sync_p1 & ~sync_p2;
  assign tick        = (prescaler == TICK_LAST);
  assign next_period = {1'b0, period} + INC_P;
  assign next_pos    = (pos_o == 3'd5) ? 3'd0 : pos_o + 3'd1;

`ifdef SPINNER_RANDOM_EN
  logic [7:0] lfsr;

  // Free-running x^8+x^6+x^5+x^4+1 sequence; runs in every state so entry offset is unpredictable
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) lfsr <= 8'hA5;
    else            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  assign entry_pos = mod6({1'b0, pos_o} + {1'b0, lfsr[2:0]});
`else
  assign entry_pos = mod6({1'b0, pos_o});
`endif

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state     <= IDLE;
      pos_o     <= 3'd0;
      running_o <= 1'b0;
      done_o    <= 1'b0;
      prescaler <= 16'd0;
      step_cnt  <= 8'd0;
      period    <= 8'd0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (press) begin
            state     <= SPIN;
            running_o <= 1'b1;
            pos_o     <= entry_pos;
            period    <= START_P;
            prescaler <= 16'd0;
            step_cnt  <= 8'd0;
          end
        end
        SPIN: begin
          prescaler <= tick ? 16'd0 : prescaler + 16'd1;
          if (tick) begin
            if (step_cnt == period - 8'd1) begin
              pos_o    <= next_pos;
              step_cnt <= 8'd0;
              period   <= next_period[7:0];
              // Final step, stop and done pulse share one edge
              if (next_period > STOP_P) begin
                state     <= IDLE;
                running_o <= 1'b0;
                done_o    <= 1'b1;
              end
            end else begin
              step_cnt <= step_cnt + 8'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/spin_ctrl.md
# spin_ctrl

Spinner motion controller for the LED spinner game. On a start press, it advances a position index through six segments (0..5) with a step period that grows after every step, so the spin visibly slows down and then stops. It sits directly upstream of the guess evaluator and drives that block's position and running inputs. Its outputs also feed the segment decoder.

## Interface
Parameters:
- TICK_DIV, 1000: clock cycles per tick; valid range 1..65536.
- START_PERIOD, 2: ticks per step on the first step; must be >= 1.
- STOP_PERIOD, 40: the spin stops once the period exceeds this; must be >= START_PERIOD.
- PERIOD_INC, 1: ticks added to the period after each step; must be >= 1, and STOP_PERIOD+PERIOD_INC <= 255.

Ports:
- clk_i, input, 1: single system clock, rising edge.
- reset_n_i, input, 1: asynchronous, active-low reset.
- start_i, input, 1: start button, asynchronous level, already debounced.
- pos_o, output, 3: current segment index, 0..5, registered.
- running_o, output, 1: 1 while spinning, 0 when stopped; registered.
- done_o, output, 1: one-cycle pulse on the cycle the spin stops.

## Operation
- Reset values: pos_o=0, running_o=0, done_o=0, state IDLE. All counters and synchronizer flops are 0. The LFSR (random option only) is 8'hA5.
- Start input path:
  - start_i passes through a 2-flop synchronizer (s1, s2) and then a delay flop s3.
  - press = s2 & ~s3. A press is a rising edge only; holding start_i high produces one press.
- State machine, two states:
  - IDLE: running_o=0; pos_o holds its value.
    - On press: enter SPIN; period=START_PERIOD; prescaler=0; step count=0.
  - SPIN: running_o=1.
    - Prescaler counts 0..TICK_DIV-1 and wraps; a tick occurs at TICK_DIV-1.
    - On a tick, if step count == period-1, a step occurs. Otherwise step count increments.
    - On a step: pos_o advances (5 wraps to 0); step count=0; period += PERIOD_INC.
    - If the new period > STOP_PERIOD: go to IDLE, running_o=0, and done_o=1 for one cycle, all on that same edge.
- A press during SPIN is ignored. The edge detector keeps tracking, so a button still held when the spin ends does not retrigger.
- Period register is 8 bits unsigned; the parameter constraints guarantee no overflow. Prescaler is 16 bits.
- Number of steps per spin is fixed by the parameters. Defaults: 39 steps (periods 2..40) and 819 ticks.

## Timing
- start_i is first sampled high at edge k. press is high after edge k+1. running_o goes to 1 at edge k+2.
- First step occurs TICK_DIV*START_PERIOD cycles after SPIN entry. Step n occurs TICK_DIV*(sum of periods 1..n) cycles after entry.
- The final pos_o update, the running_o fall and the done_o pulse happen on the same edge.
- Reset asserted mid-spin forces IDLE and the reset values immediately, without waiting for a clock. After release, nothing happens until a new press.
- done_o is never asserted in IDLE except on that exit edge.

## Configuration
- SPINNER_RANDOM_EN defined:
  - An 8-bit Fibonacci LFSR (taps x^8+x^6+x^5+x^4+1, seed 8'hA5) advances every clock in all states.
  - On the SPIN entry edge, pos_o loads (pos_o + lfsr[2:0]) mod 6, so the final position is not predictable from the starting position.
- SPINNER_RANDOM_EN undefined:
  - No LFSR is built; pos_o is unchanged on SPIN entry.
  - The final position is (start pos + step count) mod 6, fully deterministic.

## Test plan
- Reset, then idle 100 cycles with start_i=0: pos_o=0, running_o=0, done_o=0 throughout.
- TICK_DIV=2, START=1, STOP=3, INC=1, random off. Press from pos 0:
  - running_o rises at edge k+2.
  - pos_o becomes 1, 2, 3 at 2, 6 and 12 cycles after SPIN entry.
  - At entry+12, running_o falls and done_o pulses once.
- Same parameters: hold start_i high for 200 cycles. Exactly one spin occurs, ending at pos 3; a second release-and-press gives a second spin ending at pos 0.
- Press again mid-spin: no effect on period, pos sequence or end time.
- Assert reset_n_i mid-spin (entry+7): outputs are 0 immediately, with no done_o pulse.
- SPINNER_RANDOM_EN defined, defaults: a reference-model LFSR predicts the pos_o value loaded at entry. The final pos_o equals (loaded + 39) mod 6.
